// File: rtl/mips_pkg.sv
// Shared fetch-path types: word width, PC increment, fetch-state encoding and
// the prefetch queue entry.
package mips_pkg;

   localparam int unsigned WORD_W = 32;
   localparam logic [WORD_W-1:0] PC_INC = 32'd4;

   typedef enum logic [1:0] {
      FS_IDLE    = 2'd0,
      FS_REQ     = 2'd1,
      FS_DISCARD = 2'd2,
      FS_ERR     = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pcplus4;
   } ifq_entry_t;

   // Fetch addresses are always word aligned; the low two bits are dropped.
   function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
      return {addr[WORD_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular buffer holding fetched {instr, pcplus4} pairs.
// Flush (and reset) empties the buffer and rewinds both pointers.
module fetch_fifo
   import mips_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  ifq_entry_t       push_data,
   output ifq_entry_t       head,
   output logic [CNT_W-1:0] count
);

   ifq_entry_t       mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush && !rst) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit with a small prefetch queue, redirect/discard handling
// and imem timeout detection. Define IFQ_STATS_EN to add stall/flush counters.
module instr_fetch_queue
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] start_pc,
   output logic              imem_req,
   output logic [WORD_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [WORD_W-1:0] imem_rdata,
   input  logic              redirect,
   input  logic [WORD_W-1:0] redirect_pc,
   input  logic              id_ready,
   output logic              id_valid,
   output logic [WORD_W-1:0] id_instr,
   output logic [WORD_W-1:0] id_pcplus4,
   output logic              fetch_err
`ifdef IFQ_STATS_EN
   ,
   output logic [31:0]       stall_cycles,
   output logic [15:0]       flush_count
`endif
);

   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
   localparam int unsigned WAIT_W = 4;

   localparam logic [1:0] S_IDLE    = FS_IDLE;
   localparam logic [1:0] S_REQ     = FS_REQ;
   localparam logic [1:0] S_DISCARD = FS_DISCARD;
   localparam logic [1:0] S_ERR     = FS_ERR;

   logic [1:0]        state, state_next;
   logic [WORD_W-1:0] pc, pc_next;
   logic [WORD_W-1:0] disc_addr, disc_addr_next;
   logic [WAIT_W-1:0] wait_cnt, wait_next;
   logic              err_next;
   logic              push, pop, flush;
   ifq_entry_t        push_data;
   ifq_entry_t        head;
   logic [CNT_W-1:0]  count;
   logic              timeout;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .flush     (flush),
      .push_data (push_data),
      .head      (head),
      .count     (count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         pc        <= word_align(start_pc);
         disc_addr <= '0;
         wait_cnt  <= '0;
         fetch_err <= 1'b0;
      end else begin
         state     <= state_next;
         pc        <= pc_next;
         disc_addr <= disc_addr_next;
         wait_cnt  <= wait_next;
         fetch_err <= err_next;
      end
   end

   assign timeout = !imem_ack && (wait_cnt == WAIT_W'(WAIT_MAX));

   // Next-state, queue control and fetch address update.
   always_comb begin
      state_next        = state;
      pc_next           = pc;
      disc_addr_next    = disc_addr;
      wait_next         = wait_cnt;
      err_next          = fetch_err;
      push              = 1'b0;
      flush             = 1'b0;
      pop               = id_valid && id_ready && !redirect && (state != S_ERR);
      push_data.instr   = imem_rdata;
      push_data.pcplus4 = pc + PC_INC;
      case (state)
         S_IDLE: begin
            wait_next = '0;
            if (redirect) begin
               flush      = 1'b1;
               pc_next    = word_align(redirect_pc);
               state_next = S_REQ;
            end else if (count < CNT_W'(DEPTH)) begin
               state_next = S_REQ;
            end
         end
         S_REQ: begin
            if (imem_ack) begin
               wait_next = '0;
               if (redirect) begin
                  flush   = 1'b1;
                  pc_next = word_align(redirect_pc);
               end else begin
                  push    = 1'b1;
                  pc_next = pc + PC_INC;
                  // Keep issuing only if the slot just filled leaves room.
                  if (!(pop || (count < CNT_W'(DEPTH - 1)))) state_next = S_IDLE;
               end
            end else if (timeout) begin
               flush      = 1'b1;
               err_next   = 1'b1;
               state_next = S_ERR;
            end else begin
               wait_next = wait_cnt + WAIT_W'(1);
               if (redirect) begin
                  flush          = 1'b1;
                  disc_addr_next = pc;
                  pc_next        = word_align(redirect_pc);
                  state_next     = S_DISCARD;
               end
            end
         end
         S_DISCARD: begin
            if (redirect) begin
               flush   = 1'b1;
               pc_next = word_align(redirect_pc);
            end
            if (imem_ack) begin
               wait_next  = '0;
               state_next = S_REQ;
            end else if (timeout) begin
               flush      = 1'b1;
               err_next   = 1'b1;
               state_next = S_ERR;
            end else begin
               wait_next = wait_cnt + WAIT_W'(1);
            end
         end
         default: begin
            pop = 1'b0;
         end
      endcase
   end

   assign imem_req   = (state == S_REQ) || (state == S_DISCARD);
   assign imem_addr  = (state == S_DISCARD) ? disc_addr : pc;
   assign id_valid   = (count != '0);
   assign id_instr   = id_valid ? head.instr   : '0;
   assign id_pcplus4 = id_valid ? head.pcplus4 : '0;

`ifdef IFQ_STATS_EN
   // Saturating observability counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (id_valid && !id_ready && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 32'd1;
         if (redirect && (state != S_ERR) && (flush_count != '1))
            flush_count <= flush_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized and directed bench for instr_fetch_queue against a queue-based
// reference model of the fetch protocol.
module tb_instr_fetch_queue;

   localparam int unsigned DEPTH    = 4;
   localparam int unsigned WAIT_MAX = 15;

   logic        clk = 1'b0;
   logic        rst, imem_req, imem_ack, redirect, id_ready, id_valid, fetch_err;
   logic [31:0] start_pc, imem_addr, imem_rdata, redirect_pc, id_instr, id_pcplus4;
`ifdef IFQ_STATS_EN
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;
`endif

   always #5 clk = ~clk;

   instr_fetch_queue #(.DEPTH(DEPTH), .WAIT_MAX(WAIT_MAX)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_pc    (start_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_ready    (id_ready),
      .id_valid    (id_valid),
      .id_instr    (id_instr),
      .id_pcplus4  (id_pcplus4),
      .fetch_err   (fetch_err)
`ifdef IFQ_STATS_EN
      ,
      .stall_cycles(stall_cycles),
      .flush_count (flush_count)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: queue contents plus the single outstanding request.
   logic [31:0] q_instr[$];
   logic [31:0] q_pc4[$];
   logic [31:0] m_pc, m_addr;
   bit          m_busy, m_drop, m_err;
   int unsigned m_wait, m_stall, m_flush;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic model_step();
      bit valid, pop, acked, was_busy, issue;
      int unsigned size_before;
      if (rst) begin
         m_pc = {start_pc[31:2], 2'b00};
         m_busy = 0; m_drop = 0; m_err = 0; m_wait = 0;
         m_stall = 0; m_flush = 0;
         q_instr.delete(); q_pc4.delete();
         return;
      end
      valid = (q_instr.size() != 0);
      if (valid && !id_ready) m_stall++;
      if (redirect && !m_err) m_flush++;
      if (m_err) return;
      if (m_busy && !imem_ack && m_wait == WAIT_MAX) begin
         m_err = 1; m_busy = 0;
         q_instr.delete(); q_pc4.delete();
         return;
      end
      size_before = q_instr.size();
      was_busy    = m_busy;
      pop         = valid && id_ready && !redirect;
      acked       = m_busy && imem_ack;
      if (acked) begin
         if (!m_drop && !redirect) begin
            q_instr.push_back(imem_rdata);
            q_pc4.push_back(m_addr + 32'd4);
            m_pc = m_addr + 32'd4;
         end
         m_busy = 0;
      end else if (m_busy) begin
         m_wait++;
      end
      if (pop) begin
         void'(q_instr.pop_front());
         void'(q_pc4.pop_front());
      end
      if (redirect) begin
         q_instr.delete(); q_pc4.delete();
         m_pc = {redirect_pc[31:2], 2'b00};
         if (m_busy) m_drop = 1;
      end
      if (acked) issue = m_drop || redirect || (q_instr.size() < DEPTH);
      else       issue = !was_busy && (redirect || (size_before < DEPTH));
      if (issue) begin
         m_busy = 1; m_drop = 0; m_wait = 0; m_addr = m_pc;
      end
   endtask

   task automatic compare_all();
      logic [31:0] e_instr, e_pc4;
      e_instr = (q_instr.size() != 0) ? q_instr[0] : 32'd0;
      e_pc4   = (q_pc4.size() != 0)   ? q_pc4[0]   : 32'd0;
      check("imem_req", 32'(imem_req), 32'(m_busy));
      if (m_busy) check("imem_addr", imem_addr, m_addr);
      check("id_valid", 32'(id_valid), 32'(q_instr.size() != 0));
      check("id_instr", id_instr, e_instr);
      check("id_pcplus4", id_pcplus4, e_pc4);
      check("fetch_err", 32'(fetch_err), 32'(m_err));
`ifdef IFQ_STATS_EN
      check("stall_cycles", stall_cycles, m_stall);
      check("flush_count", 32'(flush_count), 32'(m_flush));
`endif
   endtask

   task automatic step(input bit r, input bit rd, input logic [31:0] rpc, input bit ack,
                       input logic [31:0] rdata, input bit rdy);
      rst = r; redirect = rd; redirect_pc = rpc;
      imem_ack = ack; imem_rdata = rdata; id_ready = rdy;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   // Reset, then release with a stray ack that must be ignored.
   task automatic do_reset(input logic [31:0] sp);
      start_pc = sp;
      step(1, 0, 0, 1, 32'hBAD0_0001, 1);
      step(0, 0, 0, 1, 32'hBAD0_0002, 1);
   endtask

   task automatic zw(input bit rdy);
      step(0, 0, 0, m_busy, instr_of(m_addr), rdy);
   endtask

   initial begin
      bit r, rd, ak, rdy;
      rst = 1; redirect = 0; redirect_pc = 0; imem_ack = 0; imem_rdata = 0;
      id_ready = 0; start_pc = 32'd320;

      // Reset state and first request
      start_pc = 32'd320;
      step(1, 0, 0, 0, 0, 1);
      check("rst_id_valid", 32'(id_valid), 32'd0);
      check("rst_id_pc4", id_pcplus4, 32'd0);
      step(0, 0, 0, 1, 32'hBAD0_0003, 1);
      check("first_req", 32'(imem_req), 32'd1);

      // Zero-wait streaming
      for (int i = 0; i < 3; i++) begin
         check("stream_addr", imem_addr, 32'd320 + 32'(4 * i));
         zw(1);
         check("stream_pc4", id_pcplus4, 32'd324 + 32'(4 * i));
      end

      // Stall fills queue, then drains in order
      do_reset(32'd320);
      for (int i = 0; i < 6; i++) zw(0);
      check("full_req_low", 32'(imem_req), 32'd0);
      check("full_head", id_pcplus4, 32'd324);
      for (int i = 0; i < 4; i++) begin
         check("drain_pc4", id_pcplus4, 32'd324 + 32'(4 * i));
         step(0, 0, 0, 0, 0, 1);
      end

      // Redirect during a slow request goes through DISCARD
      do_reset(32'd320);
      step(0, 1, 32'd400, 0, 0, 1);
      check("discard_addr", imem_addr, 32'd320);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 32'hDEAD_BEEF, 1);
      check("post_discard_addr", imem_addr, 32'd400);
      check("stale_dropped", 32'(id_valid), 32'd0);
      zw(0);
      check("redir_instr", id_instr, instr_of(32'd400));
      check("redir_pc4", id_pcplus4, 32'd404);

      // Redirect coincident with ack; unaligned target
      do_reset(32'd320);
      zw(1);
      zw(1);
      check("pre_redir_addr", imem_addr, 32'd328);
      step(0, 1, 32'd403, 1, instr_of(32'd328), 1);
      check("coinc_empty", 32'(id_valid), 32'd0);
      check("coinc_next_addr", imem_addr, 32'd400);

      // Timeout boundary, sticky error, recovery by reset
      do_reset(32'd320);
      for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 0, 1);
      check("no_err_at_15", 32'(fetch_err), 32'd0);
      step(0, 0, 0, 0, 0, 1);
      check("err_at_16", 32'(fetch_err), 32'd1);
      check("err_req_low", 32'(imem_req), 32'd0);
      step(0, 1, 32'd500, 1, 32'h1234_5678, 1);
      check("err_sticky", 32'(fetch_err), 32'd1);
      do_reset(32'd320);
      check("recover_err", 32'(fetch_err), 32'd0);
      check("recover_addr", imem_addr, 32'd320);

`ifdef IFQ_STATS_EN
      do_reset(32'd320);
      zw(0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
      step(0, 1, 32'd400, 0, 0, 1);
      step(0, 1, 32'd800, 0, 0, 0);
      check("stats_stall5", stall_cycles, 32'd5);
      check("stats_flush2", 32'(flush_count), 32'd2);
`endif

      // Randomized traffic
      do_reset(32'd320);
      for (int i = 0; i < 4000; i++) begin
         r   = ($urandom_range(0, 299) == 0);
         rd  = ($urandom_range(0, 11) == 0);
         ak  = ($urandom_range(0, 9) < 6);
         rdy = ($urandom_range(0, 9) < 7);
         if (r) start_pc = $urandom();
         step(r, rd, $urandom(), ak, $urandom(), rdy);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
